// File: rtl/alu_ctrl_pkg.sv
// Shared constants, state type and ALU op helper for the RV32 ALU control block.
package alu_ctrl_pkg;

    // Major opcodes (instr[6:2])
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    // ALU operation codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_INV  = 4'b1111;

    // Branch condition meaning "no branch"
    localparam logic [2:0] BR_NONE = 3'b010;

    // funct7 patterns
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    // Integer ALU op for a funct3; alt selects SUB/SRA on the shared encodings.
    function automatic logic [3:0] alu_op_of(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_INV;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_control_seq_decode.sv
// Purely combinational field decode: ALU op, branch condition, illegal flag and mul/div class.
module alu_decode
    import alu_ctrl_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic       valid,
    input  logic [4:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    output logic [3:0] alu_op,
    output logic [2:0] branch,
    output logic       illegal,
    output logic       is_md,
    output logic       md_class
);

    // Decode opcode/funct3/funct7; every path starts from the "invalid" defaults.
    always_comb begin
        alu_op   = ALU_INV;
        branch   = BR_NONE;
        illegal  = valid;
        is_md    = 1'b0;
        md_class = 1'b0;
        if (valid) begin
            case (opcode)
                OPC_OP: begin
                    if (f7 == F7_BASE) begin
                        alu_op  = alu_op_of(f3, 1'b0);
                        illegal = 1'b0;
                    end else if ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
                        alu_op  = alu_op_of(f3, 1'b1);
                        illegal = 1'b0;
                    end else if ((M_EXT != 0) && (f7 == F7_MEXT)) begin
                        is_md    = 1'b1;
                        md_class = f3[2];
                        illegal  = 1'b0;
                    end else begin
                        alu_op  = ALU_INV;
                        illegal = 1'b1;
                    end
                end
                OPC_OPIMM: begin
                    // funct7 is only an opcode extension for the shift immediates
                    if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                        if (f7 == F7_BASE) begin
                            alu_op  = alu_op_of(f3, 1'b0);
                            illegal = 1'b0;
                        end else if ((f3 == 3'b101) && (f7 == F7_ALT)) begin
                            alu_op  = ALU_SRA;
                            illegal = 1'b0;
                        end else begin
                            alu_op  = ALU_INV;
                            illegal = 1'b1;
                        end
                    end else begin
                        alu_op  = alu_op_of(f3, 1'b0);
                        illegal = 1'b0;
                    end
                end
                OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_AUIPC, OPC_LUI: begin
                    alu_op  = ALU_ADD;
                    illegal = 1'b0;
                end
                OPC_BRANCH: begin
                    case (f3)
                        3'b000, 3'b001: begin
                            alu_op  = ALU_XOR;
                            branch  = f3;
                            illegal = 1'b0;
                        end
                        3'b100, 3'b101: begin
                            alu_op  = ALU_SLT;
                            branch  = f3;
                            illegal = 1'b0;
                        end
                        3'b110, 3'b111: begin
                            alu_op  = ALU_SLTU;
                            branch  = f3;
                            illegal = 1'b0;
                        end
                        default: begin
                            alu_op  = ALU_INV;
                            branch  = BR_NONE;
                            illegal = 1'b1;
                        end
                    endcase
                end
                default: begin
                    alu_op  = ALU_INV;
                    illegal = 1'b1;
                end
            endcase
        end else begin
            alu_op  = ALU_INV;
            branch  = BR_NONE;
            illegal = 1'b0;
        end
    end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control with RV32M sequencing: decode plus a mul/div busy counter, stall and flush abort.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int M_EXT      = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       valid_i,
    input  logic       flush_i,
    input  logic [4:0] opcode_i,
    input  logic [2:0] f3_i,
    input  logic [6:0] f7_i,
    output logic [3:0] aluoperacion_o,
    output logic [2:0] branch_ctrl_o,
    output logic       illegal_o,
    output logic       md_start_o,
    output logic [2:0] md_op_o,
    output logic       md_kill_o,
    output logic       md_wb_o,
    output logic       stall_o
);

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    md_state_t  state_r, state_nxt_s;
    logic [5:0] cnt_r, cnt_nxt_s;
    logic [2:0] md_op_r, md_op_nxt_s;
    logic       busy_s;
    logic       dec_valid_s;
    logic [4:0] dec_opcode_s;
    logic [2:0] dec_f3_s;
    logic [6:0] dec_f7_s;
    logic       dec_is_md_s, dec_md_class_s;
    logic       start_s, kill_s, wb_s, stall_s;

    // While busy the core is stalled, so decode from the held mul/div instruction.
    assign busy_s       = (state_r == MD_BUSY);
    assign dec_valid_s  = busy_s ? 1'b1    : valid_i;
    assign dec_opcode_s = busy_s ? OPC_OP  : opcode_i;
    assign dec_f3_s     = busy_s ? md_op_r : f3_i;
    assign dec_f7_s     = busy_s ? F7_MEXT : f7_i;

    alu_decode #(
        .M_EXT (M_EXT)
    ) u_decode (
        .valid    (dec_valid_s),
        .opcode   (dec_opcode_s),
        .f3       (dec_f3_s),
        .f7       (dec_f7_s),
        .alu_op   (aluoperacion_o),
        .branch   (branch_ctrl_o),
        .illegal  (illegal_o),
        .is_md    (dec_is_md_s),
        .md_class (dec_md_class_s)
    );

    // Next-state, counter and handshake pulses for the mul/div sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        md_op_nxt_s = md_op_r;
        start_s     = 1'b0;
        kill_s      = 1'b0;
        wb_s        = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            MD_IDLE: begin
                if (dec_is_md_s && valid_i && !flush_i) begin
                    start_s     = 1'b1;
                    stall_s     = 1'b1;
                    md_op_nxt_s = f3_i;
                    cnt_nxt_s   = dec_md_class_s ? DIV_LOAD : MUL_LOAD;
                    state_nxt_s = MD_BUSY;
                end else begin
                    state_nxt_s = MD_IDLE;
                end
            end
            MD_BUSY: begin
                stall_s = 1'b1;
                if (flush_i) begin
                    kill_s      = 1'b1;
                    cnt_nxt_s   = 6'd0;
                    state_nxt_s = MD_IDLE;
                end else if (cnt_r == 6'd0) begin
                    state_nxt_s = MD_DONE;
                end else begin
                    cnt_nxt_s = cnt_r - 6'd1;
                end
            end
            MD_DONE: begin
                wb_s        = !flush_i;
                state_nxt_s = MD_IDLE;
            end
            default: begin
                cnt_nxt_s   = 6'd0;
                state_nxt_s = MD_IDLE;
            end
        endcase
    end

    // Sequencer state, busy counter and latched mul/div op.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= MD_IDLE;
            cnt_r   <= 6'd0;
            md_op_r <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            md_op_r <= md_op_nxt_s;
        end
    end

    // Reset silences the handshake immediately even if a mul/div sits on the inputs.
    assign md_start_o = start_s & rst_ni;
    assign md_kill_o  = kill_s & rst_ni;
    assign md_wb_o    = wb_s & rst_ni;
    assign stall_o    = stall_s & rst_ni;
    assign md_op_o    = md_start_o ? f3_i : md_op_r;

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench: timeline model of the mul/div handshake plus table-driven decode model.
module tb_alu_control_seq;

    localparam int MUL_C = 4;
    localparam int DIV_C = 32;

    logic       clk, rst_ni, valid_i, flush_i;
    logic [4:0] opcode_i;
    logic [2:0] f3_i;
    logic [6:0] f7_i;

    logic [3:0] alu0, alu1;
    logic [2:0] br0, br1, op0, op1;
    logic       ill0, ill1, st0, st1, kill0, kill1, wb0, wb1, stall0, stall1;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;

    // literal pins set by the stimulus, checked on the next falling edge (instance with M_EXT=1)
    bit         pin_dec, pin_md, pin_m0;
    logic [3:0] pin_alu;
    logic [2:0] pin_br;
    logic       pin_ill, pin_start, pin_stall, pin_wb, pin_kill, pin_ill0, pin_start0;

    // model state per instance: 0 = M_EXT 0, 1 = M_EXT 1
    bit   have_job [2];
    int   job_t    [2];
    int   job_len  [2];
    logic [2:0] job_op [2];

    alu_control_seq #(.MUL_CYCLES(4), .DIV_CYCLES(32), .M_EXT(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .flush_i(flush_i),
        .opcode_i(opcode_i), .f3_i(f3_i), .f7_i(f7_i),
        .aluoperacion_o(alu1), .branch_ctrl_o(br1), .illegal_o(ill1),
        .md_start_o(st1), .md_op_o(op1), .md_kill_o(kill1), .md_wb_o(wb1), .stall_o(stall1)
    );

    alu_control_seq #(.MUL_CYCLES(4), .DIV_CYCLES(32), .M_EXT(0)) u_dut_nom (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .flush_i(flush_i),
        .opcode_i(opcode_i), .f3_i(f3_i), .f7_i(f7_i),
        .aluoperacion_o(alu0), .branch_ctrl_o(br0), .illegal_o(ill0),
        .md_start_o(st0), .md_op_o(op0), .md_kill_o(kill0), .md_wb_o(wb0), .stall_o(stall0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, ncyc, act, exp);
        end
    endtask

    // Reference decode straight from the encoding tables.
    function automatic void ref_decode(input logic v, input logic [4:0] opc, input logic [2:0] f3,
                                       input logic [6:0] f7, input bit mext,
                                       output logic [3:0] alu, output logic [2:0] br,
                                       output logic ill, output bit md, output bit dv);
        logic [3:0] base [8];
        base = '{4'b0010, 4'b1001, 4'b0101, 4'b0110, 4'b0100, 4'b1010, 4'b0001, 4'b0000};
        alu = 4'b1111; br = 3'b010; ill = v; md = 1'b0; dv = 1'b0;
        if (!v) return;
        if (opc == 5'b01100) begin
            if (f7 == 7'b0000000) begin alu = base[f3]; ill = 1'b0; end
            else if (f7 == 7'b0100000 && f3 == 3'b000) begin alu = 4'b0011; ill = 1'b0; end
            else if (f7 == 7'b0100000 && f3 == 3'b101) begin alu = 4'b1011; ill = 1'b0; end
            else if (f7 == 7'b0000001 && mext) begin md = 1'b1; dv = f3[2]; ill = 1'b0; end
        end else if (opc == 5'b00100) begin
            if (f3 == 3'b001 || f3 == 3'b101) begin
                if (f7 == 7'b0000000) begin alu = base[f3]; ill = 1'b0; end
                else if (f3 == 3'b101 && f7 == 7'b0100000) begin alu = 4'b1011; ill = 1'b0; end
            end else begin
                alu = base[f3]; ill = 1'b0;
            end
        end else if (opc inside {5'b00000, 5'b01000, 5'b11011, 5'b11001, 5'b00101, 5'b01101}) begin
            alu = 4'b0010; ill = 1'b0;
        end else if (opc == 5'b11000 && f3 != 3'b010 && f3 != 3'b011) begin
            br = f3; ill = 1'b0;
            alu = (f3[2] == 1'b0) ? 4'b0100 : (f3[1] ? 4'b0110 : 4'b0101);
        end
    endfunction

    // Single compare process: model every cycle for both instances, then the literal pins.
    always @(negedge clk) begin
        logic [3:0] e_alu, a_alu;
        logic [2:0] e_br, a_br, a_op;
        logic       e_ill, a_ill, e_start, e_stall, e_kill, e_wb;
        logic       a_start, a_stall, a_kill, a_wb;
        bit         e_md, e_div, busy_now, done_now;
        ncyc++;
        for (int k = 0; k < 2; k++) begin
            a_alu   = (k == 1) ? alu1 : alu0;
            a_br    = (k == 1) ? br1 : br0;
            a_ill   = (k == 1) ? ill1 : ill0;
            a_start = (k == 1) ? st1 : st0;
            a_op    = (k == 1) ? op1 : op0;
            a_kill  = (k == 1) ? kill1 : kill0;
            a_wb    = (k == 1) ? wb1 : wb0;
            a_stall = (k == 1) ? stall1 : stall0;
            e_start = 1'b0; e_stall = 1'b0; e_kill = 1'b0; e_wb = 1'b0;
            busy_now = have_job[k] && (ncyc > job_t[k]) && (ncyc <= job_t[k] + job_len[k]);
            done_now = have_job[k] && (ncyc == job_t[k] + job_len[k] + 1);
            if (!rst_ni) begin
                ref_decode(valid_i, opcode_i, f3_i, f7_i, k == 1, e_alu, e_br, e_ill, e_md, e_div);
                have_job[k] = 1'b0;
            end else if (busy_now) begin
                ref_decode(1'b1, 5'b01100, job_op[k], 7'b0000001, k == 1, e_alu, e_br, e_ill, e_md, e_div);
                e_stall = 1'b1;
                e_kill  = flush_i;
                chk($sformatf("dut%0d_md_op_busy", k), 8'(a_op), 8'(job_op[k]));
                if (flush_i) have_job[k] = 1'b0;
            end else if (done_now) begin
                ref_decode(valid_i, opcode_i, f3_i, f7_i, k == 1, e_alu, e_br, e_ill, e_md, e_div);
                e_wb = !flush_i;
                have_job[k] = 1'b0;
            end else begin
                ref_decode(valid_i, opcode_i, f3_i, f7_i, k == 1, e_alu, e_br, e_ill, e_md, e_div);
                if (e_md && valid_i && !flush_i) begin
                    e_start = 1'b1;
                    e_stall = 1'b1;
                    have_job[k] = 1'b1;
                    job_t[k]    = ncyc;
                    job_len[k]  = e_div ? DIV_C : MUL_C;
                    job_op[k]   = f3_i;
                    chk($sformatf("dut%0d_md_op_start", k), 8'(a_op), 8'(f3_i));
                end
            end
            chk($sformatf("dut%0d_aluop", k), 8'(a_alu), 8'(e_alu));
            chk($sformatf("dut%0d_branch", k), 8'(a_br), 8'(e_br));
            chk($sformatf("dut%0d_illegal", k), 8'(a_ill), 8'(e_ill));
            chk($sformatf("dut%0d_start", k), 8'(a_start), 8'(e_start));
            chk($sformatf("dut%0d_stall", k), 8'(a_stall), 8'(e_stall));
            chk($sformatf("dut%0d_kill", k), 8'(a_kill), 8'(e_kill));
            chk($sformatf("dut%0d_wb", k), 8'(a_wb), 8'(e_wb));
        end
        if (pin_dec) begin
            chk("pin_aluop", 8'(alu1), 8'(pin_alu));
            chk("pin_branch", 8'(br1), 8'(pin_br));
            chk("pin_illegal", 8'(ill1), 8'(pin_ill));
        end
        if (pin_md) begin
            chk("pin_start", 8'(st1), 8'(pin_start));
            chk("pin_stall", 8'(stall1), 8'(pin_stall));
            chk("pin_wb", 8'(wb1), 8'(pin_wb));
            chk("pin_kill", 8'(kill1), 8'(pin_kill));
        end
        if (pin_m0) begin
            chk("pin_nomext_illegal", 8'(ill0), 8'(pin_ill0));
            chk("pin_nomext_start", 8'(st0), 8'(pin_start0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        pin_dec = 1'b0; pin_md = 1'b0; pin_m0 = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [4:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic fl);
        valid_i = v; opcode_i = opc; f3_i = f3; f7_i = f7; flush_i = fl;
    endtask

    task automatic pin_d(input logic [3:0] a, input logic [2:0] b, input logic i);
        pin_dec = 1'b1; pin_alu = a; pin_br = b; pin_ill = i;
    endtask

    task automatic pin_m(input logic s, input logic st, input logic w, input logic kl);
        pin_md = 1'b1; pin_start = s; pin_stall = st; pin_wb = w; pin_kill = kl;
    endtask

    task automatic vec(input logic [4:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [3:0] a, input logic [2:0] b, input logic i);
        step();
        drive(1'b1, opc, f3, f7, 1'b0);
        pin_d(a, b, i);
    endtask

    localparam logic [4:0] R  = 5'b01100;
    localparam logic [4:0] I  = 5'b00100;
    localparam logic [6:0] MX = 7'b0000001;

    initial begin
        pin_dec = 1'b0; pin_md = 1'b0; pin_m0 = 1'b0;
        rst_ni = 1'b0;
        drive(1'b0, 5'b00000, 3'b000, 7'b0000000, 1'b0);
        step();
        pin_m(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_ni = 1'b1;

        // decode directed vectors with literal expectations
        vec(R, 3'b000, 7'b0100000, 4'b0011, 3'b010, 1'b0);
        vec(I, 3'b000, 7'b0100000, 4'b0010, 3'b010, 1'b0);
        vec(R, 3'b010, 7'b0100000, 4'b1111, 3'b010, 1'b1);
        vec(5'b11000, 3'b110, 7'b0000000, 4'b0110, 3'b110, 1'b0);
        vec(5'b11000, 3'b011, 7'b0000000, 4'b1111, 3'b010, 1'b1);
        vec(I, 3'b101, 7'b0100000, 4'b1011, 3'b010, 1'b0);
        vec(5'b01101, 3'b000, 7'b0000000, 4'b0010, 3'b010, 1'b0);
        // decode sweeps checked by the model
        for (int f = 0; f < 8; f++) begin
            step(); drive(1'b1, R, 3'(f), 7'b0000000, 1'b0);
            step(); drive(1'b1, I, 3'(f), 7'b0100000, 1'b0);
            step(); drive(1'b1, 5'b11000, 3'(f), 7'b0000000, 1'b0);
        end
        begin
            logic [4:0] ops [8];
            ops = '{5'b00000, 5'b01000, 5'b11011, 5'b11001, 5'b00101, 5'b11111, 5'b00011, 5'b10100};
            for (int j = 0; j < 8; j++) begin
                step(); drive(1'b1, ops[j], 3'b001, 7'b1010101, 1'b0);
            end
        end
        step(); drive(1'b0, R, 3'b000, 7'b0000000, 1'b0);
        pin_d(4'b1111, 3'b010, 1'b0);

        // MUL held across two runs: start T, stall T..T+4, wb T+5, restart T+6
        step(); drive(1'b1, R, 3'b000, MX, 1'b0);
        pin_m(1'b1, 1'b1, 1'b0, 1'b0);
        pin_m0 = 1'b1; pin_ill0 = 1'b1; pin_start0 = 1'b0;
        repeat (3) step();
        step(); pin_m(1'b0, 1'b1, 1'b0, 1'b0);
        step(); pin_m(1'b0, 1'b0, 1'b1, 1'b0);
        step(); pin_m(1'b1, 1'b1, 1'b0, 1'b0);
        step(); drive(1'b1, I, 3'b000, 7'b0000000, 1'b0);
        pin_d(4'b1111, 3'b010, 1'b0);
        repeat (3) step();
        step(); pin_m(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) step();

        // DIV aborted by flush at T+7
        step(); drive(1'b1, R, 3'b100, MX, 1'b0);
        pin_m(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) step();
        step(); flush_i = 1'b1;
        pin_m(1'b0, 1'b1, 1'b0, 1'b1);
        step(); drive(1'b1, I, 3'b000, 7'b0000000, 1'b0);
        pin_m(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (30) step();

        // MUL whose writeback cycle is flushed, then mul/div under flush in idle
        step(); drive(1'b1, R, 3'b001, MX, 1'b0);
        repeat (4) step();
        step(); flush_i = 1'b1;
        pin_m(1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, R, 3'b011, MX, 1'b1);
        pin_m(1'b0, 1'b0, 1'b0, 1'b0);
        step(); drive(1'b1, I, 3'b000, 7'b0000000, 1'b0);

        // async reset while busy with cnt=5
        step(); drive(1'b1, R, 3'b110, MX, 1'b0);
        repeat (26) step();
        step(); rst_ni = 1'b0;
        pin_m(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset_immediate_stall", 8'(stall1), 8'(1'b0));
        chk("reset_immediate_md_op", 8'(op1), 8'(3'b000));
        step(); rst_ni = 1'b1;
        drive(1'b1, I, 3'b000, 7'b0000000, 1'b0);
        pin_m(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        drive(1'b0, 5'b00000, 3'b000, 7'b0000000, 1'b0);
        repeat (2) step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
